// File: rtl/clock_div_multi.sv
// N-channel programmable clock divider: each channel produces a 50%-duty
// divided clock and a one-cycle tick on every rising edge of that clock.
// Divisor writes are staged and only take effect at the channel's next wrap
// or at a sync, so a half-period is never shortened or glitched.
module clock_div_multi #(
  parameter int unsigned         CHANNELS    = 4,
  parameter int unsigned         CH_W        = 2,
  parameter int unsigned         CNT_W       = 18,
  parameter logic [CNT_W-1:0]    DEFAULT_DIV = CNT_W'(18'h3_D08F)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                sync,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [CNT_W-1:0]    wr_div,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] pend
);

  logic [CHANNELS-1:0][CNT_W-1:0] cnt_q,      cnt_d;
  logic [CHANNELS-1:0][CNT_W-1:0] div_act_q,  div_act_d;
  logic [CHANNELS-1:0][CNT_W-1:0] div_pend_q, div_pend_d;
  logic [CHANNELS-1:0]            pend_vld_q, pend_vld_d;
  logic [CHANNELS-1:0]            clk_out_q,  clk_out_d;
  logic [CHANNELS-1:0]            tick_q,     tick_d;

  // Per-channel next state: sync beats en; a write lands after any wrap/sync load
  always_comb begin
    cnt_d      = cnt_q;
    div_act_d  = div_act_q;
    div_pend_d = div_pend_q;
    pend_vld_d = pend_vld_q;
    clk_out_d  = clk_out_q;
    tick_d     = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (sync) begin
        cnt_d[c]     = '0;
        clk_out_d[c] = 1'b0;
        if (pend_vld_q[c]) begin
          div_act_d[c]  = div_pend_q[c];
          pend_vld_d[c] = 1'b0;
        end
      end else if (en) begin
        if (cnt_q[c] == div_act_q[c]) begin
          cnt_d[c]     = '0;
          clk_out_d[c] = ~clk_out_q[c];
          tick_d[c]    = ~clk_out_q[c];
          if (pend_vld_q[c]) begin
            div_act_d[c]  = div_pend_q[c];
            pend_vld_d[c] = 1'b0;
          end
        end else begin
          // Out-of-range counts simply roll over through all-ones back to 0
          cnt_d[c] = cnt_q[c] + CNT_W'(1);
        end
      end
      // Indices at or beyond CHANNELS never match, so such writes are dropped
      if (wr_en && (wr_ch == CH_W'(c))) begin
        div_pend_d[c] = wr_div;
        pend_vld_d[c] = 1'b1;
      end
    end
  end

  // State register with asynchronous reset to the default divisor
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      div_act_q  <= {CHANNELS{DEFAULT_DIV}};
      div_pend_q <= {CHANNELS{DEFAULT_DIV}};
      pend_vld_q <= '0;
      clk_out_q  <= '0;
      tick_q     <= '0;
    end else begin
      cnt_q      <= cnt_d;
      div_act_q  <= div_act_d;
      div_pend_q <= div_pend_d;
      pend_vld_q <= pend_vld_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign pend    = pend_vld_q;

endmodule

// File: tb/tb_clock_div_multi.sv
// Directed bench for clock_div_multi with a per-cycle scoreboard fed by a
// countdown reference model, plus fixed-value checks of key timing points.
module tb_clock_div_multi;

  localparam int unsigned CHANNELS = 4;
  localparam int unsigned CH_W     = 3;
  localparam int unsigned CNT_W    = 8;
  localparam int          DEF      = 3;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                en, sync, wr_en;
  logic [CH_W-1:0]     wr_ch;
  logic [CNT_W-1:0]    wr_div;
  logic [CHANNELS-1:0] clk_out, tick, pend;

  clock_div_multi #(
    .CHANNELS(CHANNELS), .CH_W(CH_W), .CNT_W(CNT_W), .DEFAULT_DIV(CNT_W'(DEF))
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .wr_en(wr_en),
    .wr_ch(wr_ch), .wr_div(wr_div), .clk_out(clk_out), .tick(tick), .pend(pend)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: cycles remaining in the current half-period
  int rem [CHANNELS];
  int act [CHANNELS];
  int pdv [CHANNELS];
  bit pv  [CHANNELS];
  bit mo  [CHANNELS];
  bit mt  [CHANNELS];

  logic [11:0] sb_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CHANNELS; c++) begin
      act[c] = DEF; pdv[c] = DEF; pv[c] = 0; mo[c] = 0; mt[c] = 0; rem[c] = DEF + 1;
    end
  endtask

  task automatic model_step(input bit e, input bit s, input bit w, input int ch, input int dv);
    for (int c = 0; c < CHANNELS; c++) begin
      mt[c] = 0;
      if (s) begin
        mo[c] = 0;
        if (pv[c]) begin act[c] = pdv[c]; pv[c] = 0; end
        rem[c] = act[c] + 1;
      end else if (e) begin
        if (rem[c] == 1) begin
          mo[c] = ~mo[c];
          mt[c] = mo[c];
          if (pv[c]) begin act[c] = pdv[c]; pv[c] = 0; end
          rem[c] = act[c] + 1;
        end else begin
          rem[c] = rem[c] - 1;
        end
      end
      if (w && ch == c) begin pdv[c] = dv; pv[c] = 1; end
    end
  endtask

  function automatic logic [11:0] model_pack();
    logic [11:0] v;
    for (int c = 0; c < CHANNELS; c++) begin
      v[c]     = mo[c];
      v[4 + c] = mt[c];
      v[8 + c] = pv[c];
    end
    return v;
  endfunction

  // Drive one cycle: push the model's expectation, clock, then pop and compare
  task automatic step(input bit e, input bit s, input bit w, input int ch, input int dv);
    logic [11:0] exp;
    en = e; sync = s; wr_en = w; wr_ch = CH_W'(ch); wr_div = CNT_W'(dv);
    model_step(e, s, w, ch, dv);
    sb_q.push_back(model_pack());
    @(posedge clk);
    #1;
    cyc++;
    exp = sb_q.pop_front();
    check("sb_outputs", {20'd0, pend, tick, clk_out}, {20'd0, exp});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
  endtask

  // Asynchronous reset away from any edge; outputs must clear without a clock
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_clk_out", {28'd0, clk_out}, 32'd0);
    check("rst_tick",    {28'd0, tick},    32'd0);
    check("rst_pend",    {28'd0, pend},    32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    rst_n = 1'b0; en = 0; sync = 0; wr_en = 0; wr_ch = '0; wr_div = '0;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // 1: default divisor, fixed tick/clock schedule
    for (int k = 1; k <= 32; k++) begin
      step(1, 0, 0, 0, 0);
      check("t1_tick", {28'd0, tick},    (k % 8 == 4) ? 32'hF : 32'h0);
      check("t1_clk",  {28'd0, clk_out}, ((k / 4) % 2 == 1) ? 32'hF : 32'h0);
    end
    check("t1_pend", {28'd0, pend}, 32'd0);

    // 2: write ch1 div=1 at cycle 6, applied at the cycle-8 wrap
    do_reset();
    run(5);
    step(1, 0, 1, 1, 1);
    check("t2_pend_set", {28'd0, pend}, 32'h2);
    step(1, 0, 0, 0, 0);
    check("t2_pend_hold", {28'd0, pend}, 32'h2);
    step(1, 0, 0, 0, 0);
    check("t2_pend_clr", {28'd0, pend}, 32'h0);
    run(2);
    check("t2_ch1_tick", {28'd0, tick}, 32'h2);
    run(9);

    // 3: freeze mid half-period, then resume
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0, 0);
      check("t3_tick_frozen", {28'd0, tick}, 32'd0);
    end
    run(12);

    // 4: ch2 div=0 then sync; ch0 write coincides with the sync
    step(1, 0, 1, 2, 0);
    step(1, 1, 1, 0, 2);
    check("t4_sync_clk", {28'd0, clk_out}, 32'd0);
    check("t4_pend", {28'd0, pend}, 32'h1);
    step(1, 0, 0, 0, 0);
    check("t4_ch2_fast", {28'd0, tick & 4'h4}, 32'h4);
    run(16);

    // 5: valid ch3 write, then a write to a nonexistent channel
    step(1, 0, 1, 3, 5);
    check("t5_pend3", {28'd0, pend & 4'h8}, 32'h8);
    step(1, 0, 1, 4, 7);
    run(30);
    check("t5_pend_all", {28'd0, pend}, 32'd0);

    // 6: pending write lost to async reset; default timing afterwards
    step(1, 0, 1, 0, 2);
    check("t6_pend0", {28'd0, pend & 4'h1}, 32'h1);
    run(1);
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      step(1, 0, 0, 0, 0);
      check("t6_tick", {28'd0, tick}, (k == 4) ? 32'hF : 32'h0);
    end
    check("t6_pend", {28'd0, pend}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
